// File: rtl/conv_npu_pkg.sv
// rtl/conv_npu_pkg.sv - shared types and sizes for the convolution frame sequencer
package conv_npu_pkg;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int PIX_W     = 8;
  localparam int RES_W     = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // A 3x3 kernel produces one result per fully covered window position.
  function automatic int writes_per_frame(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/conv_seq_valid_pipe.sv
// rtl/conv_seq_valid_pipe.sv - fixed-depth result tag delay line with empty flag
module conv_seq_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Shift tags one stage per cycle; stage 0 takes the new tag.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Register the delay line; reset drops every pending tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_valid = pipe_q[DEPTH-1];
  assign empty     = ~|pipe_q;

endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame read/convolve/write sequencer; CONV_SEQ_CHECK_EN adds err_count
module conv_frame_sequencer
  import conv_npu_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int RES_LAT = 4,
  parameter int AW      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_start,
  input  logic [AW-1:0]           cmd_src_base,
  input  logic [AW-1:0]           cmd_dst_base,
  input  logic                    pause,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    src_re,
  output logic [AW-1:0]           src_addr,
  input  logic [PIX_W-1:0]        src_rdata,
  output logic                    eng_start,
  output logic                    eng_pixel_valid,
  output logic [PIX_W-1:0]        eng_pixel,
  input  logic                    eng_result_valid,
  input  logic signed [RES_W-1:0] eng_result,
  input  logic                    eng_done,
`ifdef CONV_SEQ_CHECK_EN
  output logic                    err_count,
`endif
  output logic                    dst_we,
  output logic [AW-1:0]           dst_addr,
  output logic [RES_W-1:0]        dst_wdata
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);
  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] src_base_q, src_base_d;
  logic [AW-1:0] dst_base_q, dst_base_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          pix_vld_q, pix_vld_d;
  logic          tag_in;
  logic          tag_out;
  logic          pipe_empty;

  // Exit from DRAIN depends only on our own tag pipe, never on the engine's flag.
  logic unused_eng_done;
  assign unused_eng_done = eng_done;

  conv_seq_valid_pipe #(
    .DEPTH (RES_LAT)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tag_in),
    .out_valid (tag_out),
    .empty     (pipe_empty)
  );

  // Output decode: reads gated by pause in the same cycle, data/address zero when idle.
  always_comb begin
    busy            = (state_q != ST_IDLE);
    eng_start       = (state_q == ST_START);
    frame_done      = (state_q == ST_DONE);
    src_re          = (state_q == ST_STREAM) && !pause && (rd_cnt_q < NPIX_C);
    src_addr        = src_re ? (src_base_q + AW'(rd_cnt_q)) : '0;
    eng_pixel_valid = pix_vld_q;
    eng_pixel       = pix_vld_q ? src_rdata : '0;
    tag_in          = pix_vld_q & eng_result_valid;
    dst_we          = tag_out;
    dst_addr        = tag_out ? (dst_base_q + AW'(wr_cnt_q)) : '0;
    dst_wdata       = tag_out ? $unsigned(eng_result) : '0;
  end

  // Next-state and counter logic for the frame sequence.
  always_comb begin
    state_d    = state_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    pix_vld_d  = src_re;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          src_base_d = cmd_src_base;
          dst_base_d = cmd_dst_base;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          state_d    = ST_START;
        end
      end
      ST_START:  state_d = ST_STREAM;
      ST_STREAM: begin
        // All reads issued and the final pixel is on the engine bus this cycle.
        if ((rd_cnt_q == NPIX_C) && pix_vld_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (src_re) begin
      rd_cnt_d = rd_cnt_q + CW'(1);
    end
    if (tag_out) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
    end
  end

`ifdef CONV_SEQ_CHECK_EN
  localparam logic [CW-1:0] NWR_C = CW'(writes_per_frame(IMG_W, IMG_H));

  logic err_q, err_d;

  // Flag a short or long frame at DONE; a newly accepted frame clears it.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && cmd_start) begin
      err_d = 1'b0;
    end else if (state_q == ST_DONE) begin
      err_d = (wr_cnt_q != NWR_C);
    end
  end

  // Register the frame check flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

  // Sequencer state register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      pix_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      pix_vld_q  <= pix_vld_d;
    end
  end

endmodule

// File: doc/conv_frame_sequencer.md
CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

Interface
REQ-001 Parameter IMG_W, 32, image width in pixels.
REQ-002 Parameter IMG_H, 32, image height in pixels.
REQ-003 Parameter RES_LAT, 4, engine cycles from pixel accept to matching result_out.
REQ-004 Parameter AW, 16, memory address width.
REQ-005 Port clk  in  1  clock; all logic on rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-high.
REQ-007 Port cmd_start  in  1  one-cycle request to process one frame.
REQ-008 Port cmd_src_base  in  AW  pixel memory base address, sampled with cmd_start.
REQ-009 Port cmd_dst_base  in  AW  result memory base address, sampled with cmd_start.
REQ-010 Port pause  in  1  host hold; blocks new pixel reads while high.
REQ-011 Port busy  out  1  high from accepted cmd_start through DONE.
REQ-012 Port frame_done  out  1  one-cycle pulse at frame completion.
REQ-013 Port src_re, src_addr  out  1, AW  pixel memory read strobe and address; read data valid 1 cycle later.
REQ-014 Port src_rdata  in  8  pixel read data.
REQ-015 Port eng_start, eng_pixel_valid, eng_pixel  out  1, 1, 8  convolution engine drive.
REQ-016 Port eng_result_valid, eng_result, eng_done  in  1, 22 signed, 1  convolution engine outputs.
REQ-017 Port dst_we, dst_addr, dst_wdata  out  1, AW, 22  result memory write port.

Function
REQ-018 FSM states IDLE, START, STREAM, DRAIN, DONE; SHALL leave IDLE only on cmd_start.
REQ-019 cmd_start in IDLE: latch both bases, go START; cmd_start in any other state ignored.
REQ-020 START lasts one cycle with eng_start=1, then STREAM.
REQ-021 STREAM: each cycle with pause=0 and reads issued < IMG_W*IMG_H, assert src_re with src_addr = src_base + read count.
REQ-022 eng_pixel_valid SHALL equal src_re delayed one cycle; eng_pixel = src_rdata.
REQ-023 Pause mid-frame: in-flight read still delivered; no bubble corrupts order; addresses resume contiguous.
REQ-024 Result tag = eng_pixel_valid AND eng_result_valid, shifted through RES_LAT-stage valid pipe.
REQ-025 Tag exiting the pipe: dst_we=1, dst_wdata=eng_result, dst_addr = dst_base + write count, write count +1.
REQ-026 After last pixel delivered go DRAIN; leave DRAIN when valid pipe empty -> DONE.
REQ-027 DONE lasts one cycle, frame_done=1, then IDLE; eng_done is not required for exit.
REQ-028 Expected writes per frame (IMG_W-2)*(IMG_H-2) = 900 at defaults.
REQ-029 Address arithmetic wraps modulo 2^AW.

Reset
REQ-030 rst (including mid-frame) SHALL force IDLE, clear counters and valid pipe, and drive busy, frame_done, src_re, eng_start, eng_pixel_valid, dst_we to 0 in the following cycle; all data/address outputs 0.

Configuration
REQ-031 Macro CONV_SEQ_CHECK_EN defined: add output port err_count (1 bit), set in DONE when write count != (IMG_W-2)*(IMG_H-2), cleared by next accepted cmd_start or rst.
REQ-032 Macro CONV_SEQ_CHECK_EN undefined: port err_count and check logic absent.

Structure
REQ-033 Package conv_npu_pkg holds the FSM state enum, IMG_W/IMG_H defaults, pixel width 8 and result width 22.
REQ-034 Sub-module conv_seq_valid_pipe (RES_LAT-deep valid shift register with empty flag) SHALL be instantiated once.

Verification
REQ-035 Ramp frame, src_base=0x0100, dst_base=0x2000, pause=0 -> src addresses 0x0100..0x04FF contiguous; 900 writes at 0x2000..0x2383; frame_done 1 cycle; busy high throughout.
REQ-036 Constant-100 frame -> all 900 dst_wdata = 0 (Sobel-X on flat image).
REQ-037 pause toggled every 3rd cycle -> same 900 writes/values as REQ-035 reference, frame just longer.
REQ-038 cmd_start pulsed again in STREAM -> ignored; base addresses unchanged; exactly one frame_done.
REQ-039 rst asserted at pixel 500 -> next cycle all strobes 0, state IDLE; fresh cmd_start yields complete 900-write frame.
REQ-040 With CONV_SEQ_CHECK_EN, force eng_result_valid low for one tagged cycle -> 899 writes, err_count=1 at DONE.
